// File: rtl/gbf_flgact_ctrl.sv
// Flag-activation global buffer controller: single-port RAM run as a FIFO,
// with a 2-entry output buffer that hides the one-cycle RAM read latency.
module gbf_flgact_ctrl #(
    parameter int unsigned DEPTH_BIT = 6,
    parameter int unsigned WIDTH     = 28
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [DEPTH_BIT:0]   count,
    output logic [DEPTH_BIT-1:0] ram_addr_w,
    output logic [DEPTH_BIT-1:0] ram_addr_r,
    output logic                 ram_write_en,
    output logic                 ram_read_en,
    output logic [WIDTH-1:0]     ram_data_in,
    input  logic [WIDTH-1:0]     ram_data_out
);
    localparam logic [DEPTH_BIT:0] FULL = {1'b1, {DEPTH_BIT{1'b0}}};

    logic [DEPTH_BIT-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BIT-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BIT:0]   count_q, count_d;
    logic                 rd_pend_q, rd_pend_d;
    logic                 prio_rd_q, prio_rd_d;
    logic [1:0]           ob_cnt_q, ob_cnt_d;
    logic [WIDTH-1:0]     ob0_q, ob0_d;
    logic [WIDTH-1:0]     ob1_q, ob1_d;

    logic rd_want;
    logic rd_grant;
    logic wr_grant;
    logic pop;

    always_comb begin
        rd_want  = (count_q != '0) &&
                   (({1'b0, ob_cnt_q} + {2'b00, rd_pend_q}) < 3'd2);
        in_ready = !flush && (count_q != FULL) && !(rd_want && prio_rd_q);
        rd_grant = !flush && rd_want && (prio_rd_q || !in_valid);
        wr_grant = in_valid && in_ready;
        pop      = (ob_cnt_q != 2'd0) && out_ready;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_pend_d = 1'b0;
        prio_rd_d = prio_rd_q;
        ob_cnt_d  = ob_cnt_q;
        ob0_d     = ob0_q;
        ob1_d     = ob1_q;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            ob_cnt_d  = '0;
            prio_rd_d = 1'b1;
        end else begin
            if (wr_grant) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_grant) rd_ptr_d = rd_ptr_q + 1'b1;
            rd_pend_d = rd_grant;
            if (wr_grant && !rd_grant)      count_d = count_q + 1'b1;
            else if (rd_grant && !wr_grant) count_d = count_q - 1'b1;
            if (rd_grant)      prio_rd_d = 1'b0;
            else if (wr_grant) prio_rd_d = 1'b1;
            // Head shifts on pop; the returning word lands in the first free slot after it.
            if (pop) ob0_d = ob1_q;
            if (rd_pend_q) begin
                if ((ob_cnt_q == 2'd0) || (pop && (ob_cnt_q == 2'd1))) ob0_d = ram_data_out;
                else                                                    ob1_d = ram_data_out;
            end
            ob_cnt_d = ob_cnt_q + 2'(rd_pend_q) - 2'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_pend_q <= 1'b0;
            prio_rd_q <= 1'b1;
            ob_cnt_q  <= '0;
            ob0_q     <= '0;
            ob1_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_pend_q <= rd_pend_d;
            prio_rd_q <= prio_rd_d;
            ob_cnt_q  <= ob_cnt_d;
            ob0_q     <= ob0_d;
            ob1_q     <= ob1_d;
        end
    end

    assign out_valid    = (ob_cnt_q != 2'd0);
    assign out_data     = ob0_q;
    assign count        = count_q;
    assign ram_addr_w   = wr_ptr_q;
    assign ram_addr_r   = rd_ptr_q;
    assign ram_write_en = wr_grant;
    assign ram_read_en  = rd_grant;
    assign ram_data_in  = in_data;

endmodule

// File: tb/tb_gbf_flgact_ctrl.sv
// Bench for gbf_flgact_ctrl: queue-based reference model checked every cycle,
// a vector table for the single-word latency case, and directed corner sequences.
module tb_gbf_flgact_ctrl;
    localparam int DB    = 6;
    localparam int W     = 28;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [DB:0]   count;
    logic [DB-1:0] ram_addr_w;
    logic [DB-1:0] ram_addr_r;
    logic          ram_write_en;
    logic          ram_read_en;
    logic [W-1:0]  ram_data_in;
    logic [W-1:0]  ram_data_out;
    logic [W-1:0]  mem [DEPTH];

    gbf_flgact_ctrl #(.DEPTH_BIT(DB), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .ram_addr_w(ram_addr_w), .ram_addr_r(ram_addr_r),
        .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Single-port RAM the controller drives; contents survive reset.
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_addr_w] <= ram_data_in;
        if (ram_read_en)  ram_data_out <= mem[ram_addr_r];
    end

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: words in RAM, output buffer and in-flight read as plain queues.
    logic [W-1:0] m_ram[$];
    logic [W-1:0] m_ob[$];
    bit           m_pend;
    logic [W-1:0] m_pend_d;
    bit           m_prio;
    int           m_wr, m_rd;
    bit           last_wr, last_rd, last_pop;

    function automatic void model_clear();
        m_ram.delete();
        m_ob.delete();
        m_pend = 1'b0;
        m_prio = 1'b1;
        m_wr   = 0;
        m_rd   = 0;
    endfunction

    task automatic cyc(input bit v, input logic [W-1:0] d, input bit r, input bit f);
        bit want, e_rdy, e_rd, e_wr, e_ov;
        in_valid = v; in_data = d; out_ready = r; flush = f;
        @(negedge clk);
        want  = (m_ram.size() != 0) && ((m_ob.size() + int'(m_pend)) < 2);
        e_rdy = !f && (m_ram.size() != DEPTH) && !(want && m_prio);
        e_rd  = !f && want && (m_prio || !v);
        e_wr  = v && e_rdy;
        e_ov  = (m_ob.size() != 0);
        chk("in_ready",     32'(in_ready),     32'(e_rdy));
        chk("ram_read_en",  32'(ram_read_en),  32'(e_rd));
        chk("ram_write_en", 32'(ram_write_en), 32'(e_wr));
        chk("out_valid",    32'(out_valid),    32'(e_ov));
        chk("count",        32'(count),        32'(m_ram.size()));
        chk("ram_addr_w",   32'(ram_addr_w),   32'(m_wr % DEPTH));
        chk("ram_addr_r",   32'(ram_addr_r),   32'(m_rd % DEPTH));
        chk("ram_data_in",  32'(ram_data_in),  32'(d));
        if (e_ov) chk("out_data", 32'(out_data), 32'(m_ob[0]));
        last_wr  = e_wr;
        last_rd  = e_rd;
        last_pop = e_ov && r;
        if (f) begin
            model_clear();
        end else begin
            if (last_pop) void'(m_ob.pop_front());
            if (m_pend) m_ob.push_back(m_pend_d);
            m_pend = e_rd;
            if (e_rd) begin m_pend_d = m_ram.pop_front(); m_rd++; end
            if (e_wr) begin m_ram.push_back(d); m_wr++; end
            if (e_rd)      m_prio = 1'b0;
            else if (e_wr) m_prio = 1'b1;
        end
    endtask

    task automatic step(input bit v, input logic [W-1:0] d, input bit r, input bit f);
        cyc(v, d, r, f);
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit v; logic [W-1:0] d; bit r; bit f;
        bit e_rdy; bit e_wr; bit e_rd; bit e_ov; logic [W-1:0] e_dat; int e_cnt;
    } vec_t;
    vec_t tbl[5];

    initial begin
        int pushed, pops, budget, nw, nr;
        tbl[0] = '{1'b1, 28'hABCDE12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 28'h0, 0};
        tbl[1] = '{1'b0, 28'h0,       1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 28'h0, 1};
        tbl[2] = '{1'b0, 28'h0,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 28'h0, 0};
        tbl[3] = '{1'b0, 28'h0,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 28'hABCDE12, 0};
        tbl[4] = '{1'b0, 28'h0,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 28'h0, 0};

        model_clear();
        #12;
        chk("rst_out_valid", 32'(out_valid),    32'd0);
        chk("rst_in_ready",  32'(in_ready),     32'd1);
        chk("rst_read_en",   32'(ram_read_en),  32'd0);
        chk("rst_write_en",  32'(ram_write_en), 32'd0);
        chk("rst_count",     32'(count),        32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
            chk("tbl_in_ready", 32'(in_ready),     32'(tbl[i].e_rdy));
            chk("tbl_write_en", 32'(ram_write_en), 32'(tbl[i].e_wr));
            chk("tbl_read_en",  32'(ram_read_en),  32'(tbl[i].e_rd));
            chk("tbl_out_valid",32'(out_valid),    32'(tbl[i].e_ov));
            chk("tbl_count",    32'(count),        32'(tbl[i].e_cnt));
            if (tbl[i].e_ov) chk("tbl_out_data", 32'(out_data), 32'(tbl[i].e_dat));
            @(posedge clk); #1;
        end

        // Fill with the consumer stalled.
        pushed = 0; budget = 0;
        while (pushed < 64 && budget < 400) begin
            step(1'b1, W'(pushed), 1'b0, 1'b0);
            if (last_wr) pushed++;
            budget++;
        end
        chk("fill_pushed", 32'(pushed), 32'd64);
        in_valid = 1'b0; #1;
        chk("fill_count",     32'(count),     32'd62);
        chk("fill_out_valid", 32'(out_valid), 32'd1);
        chk("fill_in_ready",  32'(in_ready),  32'd1);
        budget = 0;
        while (pushed < 66 && budget < 50) begin
            step(1'b1, W'(pushed), 1'b0, 1'b0);
            if (last_wr) pushed++;
            budget++;
        end
        in_valid = 1'b0; #1;
        chk("full_count",    32'(count),    32'd64);
        chk("full_in_ready", 32'(in_ready), 32'd0);

        pops = 0; budget = 0;
        while (pops < 66 && budget < 400) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            if (last_pop) begin
                chk("drain_order", 32'(out_data), 32'(pops));
                pops++;
            end
            @(posedge clk); #1;
            budget++;
        end
        chk("drain_pops", 32'(pops), 32'd66);

        // Sustained contention from empty: strict alternation.
        nw = 0; nr = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, W'(32'h100 + i), 1'b1, 1'b0);
            nw += int'(last_wr);
            nr += int'(last_rd);
        end
        chk("alt_writes", 32'(nw), 32'd12);
        chk("alt_reads",  32'(nr), 32'd12);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic across pointer wrap.
        pushed = 0; pops = 0; budget = 0;
        while (pushed < 200 && budget < 3000) begin
            step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
            if (last_wr) pushed++;
            if (last_pop) pops++;
            budget++;
        end
        chk("rand_pushed", 32'(pushed), 32'd200);
        budget = 0;
        while ((m_ram.size() + m_ob.size() + int'(m_pend)) != 0 && budget < 400) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (last_pop) pops++;
            budget++;
        end
        chk("rand_pops", 32'(pops), 32'd200);

        // Flush with one word buffered and one read in flight.
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 28'h00000A1, 1'b0, 1'b0);
        step(1'b1, 28'h00000B2, 1'b0, 1'b0);
        step(1'b1, 28'h00000B2, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 28'h00000C3, 1'b0, 1'b1);
        chk("flush_in_ready", 32'(in_ready),     32'd0);
        chk("flush_write_en", 32'(ram_write_en), 32'd0);
        chk("flush_read_en",  32'(ram_read_en),  32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; #1;
        chk("postflush_count",     32'(count),     32'd0);
        chk("postflush_out_valid", 32'(out_valid), 32'd0);
        chk("postflush_in_ready",  32'(in_ready),  32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk("flush_no_ghost", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 6; i++) step(1'b1, W'(32'h200 + i), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid),    32'd0);
        chk("arst_in_ready",  32'(in_ready),     32'd1);
        chk("arst_read_en",   32'(ram_read_en),  32'd0);
        chk("arst_write_en",  32'(ram_write_en), 32'd0);
        chk("arst_count",     32'(count),        32'd0);
        model_clear();
        @(posedge clk); #1 rst_n = 1'b1;
        step(1'b1, 28'h5A5A5A5, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("arst_lat_valid", 32'(out_valid), 32'd1);
        chk("arst_lat_data",  32'(out_data),  32'h5A5A5A5);
        @(posedge clk); #1;
        step(1'b0, '0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
